// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative cache with true-LRU replacement and a
// selectable write-back or write-through (both write-allocate) policy.
module assoc_cache #(
    parameter int unsigned WORD_W         = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned SETS           = 4,
    parameter int unsigned WAYS           = 2,
    parameter int unsigned WRITE_BACK     = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    input  logic [ADDR_W-1:0]                cpu_addr,
    input  logic [WORD_W-1:0]                cpu_wdata,
    output logic [WORD_W-1:0]                cpu_rdata,
    output logic                             stall,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0] mem_wdata,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata,
    input  logic                             mem_ack,
    output logic [15:0]                      access_count,
    output logic [15:0]                      hit_count
);

    localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam bit          WB     = (WRITE_BACK != 0);

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        FILL,
        WTHRU
    } state_e;

    state_e            state_q, state_d;

    logic [LINE_W-1:0] lines_q [SETS][WAYS];
    logic [LINE_W-1:0] lines_d [SETS][WAYS];
    logic [TAG_W-1:0]  tags_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tags_d  [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              valid_d [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic              dirty_d [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [WAY_W-1:0]  age_d   [SETS][WAYS];

    logic [WAY_W-1:0]  vict_q, vict_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic              wt_done_q, wt_done_d;
    logic              missed_q, missed_d;
    logic              mem_read_q, mem_write_q;
    logic [15:0]       access_count_q, access_count_d;
    logic [15:0]       hit_count_q, hit_count_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              inv_found;
    logic [WAY_W-1:0]  old_age;
    logic              complete;
    logic [LINE_W-1:0] hit_line;

    assign req_off = cpu_addr[OFF_W-1:0];
    assign req_idx = cpu_addr[OFF_W +: IDX_W];
    assign req_tag = cpu_addr[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tags_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line  = lines_q[req_idx][hit_way];
    assign cpu_rdata = hit_line[WORD_W*req_off +: WORD_W];

    // Empty ways are filled lowest-first; once the set is full the oldest way goes.
    always_comb begin
        victim    = '0;
        inv_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[req_idx][w]) begin
                victim    = WAY_W'(w);
                inv_found = 1'b1;
            end
        end
        if (!inv_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        vict_d         = vict_q;
        req_idx_d      = req_idx_q;
        req_tag_d      = req_tag_q;
        lines_d        = lines_q;
        tags_d         = tags_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        age_d          = age_q;
        wt_done_d      = wt_done_q;
        missed_d       = missed_q;
        access_count_d = access_count_q;
        hit_count_d    = hit_count_q;
        stall          = 1'b0;
        complete       = 1'b0;
        old_age        = age_q[req_idx][hit_way];

        case (state_q)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    if (cpu_write && !WB && wt_done_q) begin
                        // The line was already written and sent to memory last pass.
                        wt_done_d = 1'b0;
                        complete  = 1'b1;
                    end else if (hit) begin
                        if (cpu_write) begin
                            lines_d[req_idx][hit_way][WORD_W*req_off +: WORD_W] = cpu_wdata;
                            if (WB) begin
                                dirty_d[req_idx][hit_way] = 1'b1;
                                complete                  = 1'b1;
                            end else begin
                                stall     = 1'b1;
                                vict_d    = hit_way;
                                req_idx_d = req_idx;
                                req_tag_d = req_tag;
                                state_d   = WTHRU;
                            end
                        end else begin
                            complete = 1'b1;
                        end
                    end else begin
                        stall     = 1'b1;
                        missed_d  = 1'b1;
                        vict_d    = victim;
                        req_idx_d = req_idx;
                        req_tag_d = req_tag;
                        if (WB && valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            state_d = WBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            WBACK: begin
                stall = 1'b1;
                if (mem_ack) begin
                    dirty_d[req_idx_q][vict_q] = 1'b0;
                    state_d                    = FILL;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack) begin
                    lines_d[req_idx_q][vict_q] = mem_rdata;
                    tags_d[req_idx_q][vict_q]  = req_tag_q;
                    valid_d[req_idx_q][vict_q] = 1'b1;
                    dirty_d[req_idx_q][vict_q] = 1'b0;
                    state_d                    = IDLE;
                end
            end
            WTHRU: begin
                stall = 1'b1;
                if (mem_ack) begin
                    wt_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            missed_d = 1'b0;
            if (access_count_q != 16'hFFFF) begin
                access_count_d = access_count_q + 16'd1;
            end
            if (!missed_q && (hit_count_q != 16'hFFFF)) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (hit) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_d[req_idx][w] = '0;
                    end else if (age_q[req_idx][w] < old_age) begin
                        age_d[req_idx][w] = age_q[req_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wt_done_q      <= 1'b0;
            missed_q       <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            access_count_q <= '0;
            hit_count_q    <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q        <= state_d;
            wt_done_q      <= wt_done_d;
            missed_q       <= missed_d;
            mem_read_q     <= (state_d == FILL);
            mem_write_q    <= (state_d == WBACK) || (state_d == WTHRU);
            access_count_q <= access_count_d;
            hit_count_q    <= hit_count_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            age_q          <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        lines_q   <= lines_d;
        tags_q    <= tags_d;
        vict_q    <= vict_d;
        req_idx_q <= req_idx_d;
        req_tag_q <= req_tag_d;
    end

    always_comb begin
        mem_addr = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        if (state_q == WBACK) begin
            mem_addr = {tags_q[req_idx_q][vict_q], req_idx_q, {OFF_W{1'b0}}};
        end
    end

    assign mem_wdata    = lines_q[req_idx_q][vict_q];
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign access_count = access_count_q;
    assign hit_count    = hit_count_q;

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
Parametrised N-way set-associative cache with selectable write-back or write-through policy. It replaces the fixed direct-mapped cache that sits between the pipeline datapath and line-wide memory, on both the I-side and D-side. It stalls the CPU on misses and write-through traffic, uses true-LRU replacement, and exposes access and hit statistics counters.

Parameters:
WORD_W, 16, CPU word width
ADDR_W, 16, word address width
WORDS_PER_LINE, 4, words per line (power of 2); LINE_W = WORD_W*WORDS_PER_LINE
SETS, 4, number of sets (power of 2)
WAYS, 2, associativity (power of 2, >=1)
WRITE_BACK, 1, 1 = write-back/write-allocate; 0 = write-through/write-allocate

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cpu_read  in  1  read request, held until stall=0
cpu_write  in  1  write request, held until stall=0; wins if both high
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  WORD_W  write data
cpu_rdata  out  WORD_W  read data, valid when cpu_read & !stall
stall  out  1  request not complete this cycle
mem_read  out  1  line fill request
mem_write  out  1  line write request
mem_addr  out  ADDR_W  line-aligned address (offset bits 0)
mem_wdata  out  LINE_W  line to write
mem_rdata  in  LINE_W  fill data, valid in mem_ack cycle
mem_ack  in  1  one-cycle completion pulse from memory
access_count  out  16  completed requests, saturating
hit_count  out  16  requests that hit on first lookup, saturating

Behaviour:
- Address split: offset = low log2(WORDS_PER_LINE) bits; index = next log2(SETS) bits; tag = remaining bits. Word 0 of a line is mem_rdata[WORD_W-1:0].
- Reset (at clk edge while reset_n=0): all valid/dirty bits 0; LRU age of way i = i; FSM = IDLE; counters 0; wt_done = 0; missed = 0. mem_read, mem_write = 0. Reset aborts any in-flight WBACK/FILL/WTHRU. A later mem_ack for the aborted transaction is ignored.
- Outputs: mem_read, mem_write, mem_addr, mem_wdata are decoded from state and registers only. stall and cpu_rdata are combinational from the request and the tag lookup.
- FSM states: IDLE, WBACK, FILL, WTHRU.
- IDLE, no request: stall=0.
- IDLE, read hit: stall=0; cpu_rdata = hit word in the same cycle; LRU updated at the edge.
- IDLE, write hit, WRITE_BACK=1: stall=0; word written and dirty=1 at the edge.
- IDLE, write hit, WRITE_BACK=0, wt_done=0: stall=1; word written at the edge; go to WTHRU.
- IDLE, write, WRITE_BACK=0, wt_done=1: stall=0; no rewrite; clear wt_done.
- IDLE, miss: stall=1; set missed=1.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - If WRITE_BACK=1 and victim is valid and dirty, go to WBACK; otherwise go to FILL.
- WBACK: stall=1; mem_write=1; mem_addr = {victim tag, index, 0}; mem_wdata = victim line. Held through the mem_ack cycle. On ack: victim dirty=0, go to FILL.
- FILL: stall=1; mem_read=1; mem_addr = {req tag, index, 0}. On ack: install mem_rdata into the victim way, set valid=1, dirty=0, tag, and go to IDLE. The next IDLE cycle re-looks-up and hits.
- WTHRU: stall=1; mem_write=1; mem_addr = line address; mem_wdata = updated line. On ack: wt_done=1, go to IDLE.
- mem_ack is only sampled in WBACK/FILL/WTHRU; it is ignored in IDLE. The earliest legal ack is the first cycle of a state, so the minimum miss penalty is 2 stall cycles (FILL plus re-lookup).
- LRU: on a completed access, the accessed way gets age 0. Ways whose age was below the accessed way's old age increment by 1. Ages stay a permutation of 0..WAYS-1.
- Counters:
  - access_count increments once per completed request (IDLE, request, stall=0).
  - hit_count increments on the same event when missed=0.
  - missed clears on completion.
  - Both counters saturate at 16'hFFFF.
- WAYS=1 degenerates to direct-mapped: the victim is always way 0.

Test Plan:
1. Defaults, after reset: read 0x0010 -> stall=1, mem_read=1, mem_addr=0x0010. Ack with line {DDDD,CCCC,BBBB,AAAA} -> next cycle stall=0, cpu_rdata=0xAAAA. Then read 0x0013 -> 0xDDDD with no stall. Result: access_count=2, hit_count=1.
2. Then write 0x0011=0x1234 -> stall=0, no mem traffic. Read 0x0011 -> 0x1234.
3. Then read 0x0020 (miss, fill, set 0 way 1), then read 0x0030 -> victim is dirty 0x0010 line. mem_write=1 with mem_addr=0x0010 and mem_wdata[31:16]=0x1234, then mem_read with mem_addr=0x0030. A subsequent read of 0x0020 hits.
4. WRITE_BACK=0, line 0x0010 resident: write 0x0011=0x5555 -> stall=1, then mem_write with mem_addr=0x0010 and word1=0x5555 until ack. The cycle after ack has stall=0, with exactly one mem_write transaction observed.
5. Assert reset_n=0 during FILL of 0x0040, then ack later -> mem_read=0 after the reset edge. The late ack is ignored, counters read 0, and a re-read of 0x0040 misses again.
6. Issue 65540 hits -> access_count holds at 0xFFFF and does not wrap.
